// File: rtl/filter_decim.sv
// Decimate-by-DECIM block averager with a two-state hysteresis level detector.
// Consumes the filter's sfix10_En3 stream under the shared clk_enable qualifier.
module filter_decim #(
  parameter int unsigned DECIM = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clk_enable,
  input  logic              clear,
  input  logic signed [9:0] input_rsvd,
  input  logic signed [9:0] th_hi,
  input  logic signed [9:0] th_lo,
  output logic signed [9:0] dec_out,
  output logic              dec_valid,
  output logic              level_hi,
  output logic              event_rise,
  output logic              event_fall
);

  localparam int unsigned L  = $clog2(DECIM);
  localparam int unsigned DW = 10;
  localparam int unsigned AW = DW + L;

  typedef enum logic {ST_LOW, ST_HIGH} state_t;

  state_t               state;
  logic signed [AW-1:0] acc;
  logic        [L-1:0]  ph;

  logic signed [AW-1:0] sum_c;
  logic signed [DW-1:0] avg_c;
  logic                 last_c;

  // Running sum including the current sample; its floor average is in range by construction.
  assign sum_c  = acc + AW'(input_rsvd);
  assign avg_c  = DW'(sum_c >>> L);
  assign last_c = (ph == L'(DECIM - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc        <= '0;
      ph         <= '0;
      dec_out    <= '0;
      dec_valid  <= 1'b0;
      state      <= ST_LOW;
      level_hi   <= 1'b0;
      event_rise <= 1'b0;
      event_fall <= 1'b0;
    end else begin
      dec_valid  <= 1'b0;
      event_rise <= 1'b0;
      event_fall <= 1'b0;
      if (clear) begin
        // Frame restart drops the partial sum; detector state and last average hold.
        acc <= '0;
        ph  <= '0;
      end else if (clk_enable) begin
        if (last_c) begin
          dec_out   <= avg_c;
          dec_valid <= 1'b1;
          acc       <= '0;
          ph        <= '0;
          case (state)
            ST_LOW: begin
              if (avg_c > th_hi) begin
                state      <= ST_HIGH;
                level_hi   <= 1'b1;
                event_rise <= 1'b1;
              end
            end
            ST_HIGH: begin
              if (avg_c < th_lo) begin
                state      <= ST_LOW;
                level_hi   <= 1'b0;
                event_fall <= 1'b1;
              end
            end
            default: begin
              state    <= ST_LOW;
              level_hi <= 1'b0;
            end
          endcase
        end else begin
          acc <= sum_c;
          ph  <= ph + L'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_decim.sv
// Bench for filter_decim (DECIM=4): directed vector table, hand-built clear/reset
// sequences and randomized traffic against a frame-level reference model.
module tb_filter_decim;

  localparam int unsigned DECIM = 4;

  logic              clk;
  logic              resetn;
  logic              clk_enable;
  logic              clear;
  logic signed [9:0] input_rsvd;
  logic signed [9:0] th_hi;
  logic signed [9:0] th_lo;
  logic signed [9:0] dec_out;
  logic              dec_valid;
  logic              level_hi;
  logic              event_rise;
  logic              event_fall;

  filter_decim #(.DECIM(DECIM)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .clk_enable(clk_enable),
    .clear     (clear),
    .input_rsvd(input_rsvd),
    .th_hi     (th_hi),
    .th_lo     (th_lo),
    .dec_out   (dec_out),
    .dec_valid (dec_valid),
    .level_hi  (level_hi),
    .event_rise(event_rise),
    .event_fall(event_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [9:0] x;
    logic [9:0] dec;
    logic       v;
    logic       lvl;
    logic       r;
    logic       f;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Table bookkeeping: held output values between dumps.
  logic [9:0] t_dec = 10'h000;
  logic       t_lvl = 1'b0;

  // Reference model: list of qualified samples in the current frame.
  int         m_samples[$];
  logic [9:0] m_dec = 10'h000;
  logic       m_lvl = 1'b0;
  logic       m_v = 1'b0, m_r = 1'b0, m_f = 1'b0;

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_samples.delete();
    m_dec = 10'h000;
    m_lvl = 1'b0;
    m_v = 1'b0; m_r = 1'b0; m_f = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic clr, input logic [9:0] x);
    int sum, avg, hi, lo;
    m_v = 1'b0; m_r = 1'b0; m_f = 1'b0;
    if (clr) begin
      m_samples.delete();
    end else if (en) begin
      m_samples.push_back(int'($signed(x)));
      if (m_samples.size() == DECIM) begin
        sum = 0;
        foreach (m_samples[i]) sum += m_samples[i];
        avg = floor_div(sum, DECIM);
        hi  = int'(th_hi);
        lo  = int'(th_lo);
        m_dec = 10'(avg);
        m_v   = 1'b1;
        if (!m_lvl && avg > hi) begin
          m_lvl = 1'b1; m_r = 1'b1;
        end else if (m_lvl && avg < lo) begin
          m_lvl = 1'b0; m_f = 1'b1;
        end
        m_samples.delete();
      end
    end
  endtask

  task automatic check(input string name, input logic [9:0] dec, input logic v,
                       input logic lvl, input logic r, input logic f);
    n_vec++;
    if (dec_out !== dec || dec_valid !== v || level_hi !== lvl ||
        event_rise !== r || event_fall !== f) begin
      n_err++;
      $display("FAIL %s: got dec=%h v=%b lvl=%b r=%b f=%b, want dec=%h v=%b lvl=%b r=%b f=%b",
               name, dec_out, dec_valid, level_hi, event_rise, event_fall, dec, v, lvl, r, f);
    end
  endtask

  // Present inputs, take one rising edge, then advance the model for that edge.
  task automatic drive_edge(input logic en, input logic clr, input logic [9:0] x);
    clk_enable = en;
    clear      = clr;
    input_rsvd = x;
    @(posedge clk);
    #1;
    model_edge(en, clr, x);
  endtask

  task automatic push_hold(input logic en, input logic [9:0] x);
    tbl.push_back('{en, 1'b0, x, t_dec, 1'b0, t_lvl, 1'b0, 1'b0});
  endtask

  task automatic push_dump(input logic [9:0] x, input logic [9:0] avg, input logic lvl,
                           input logic r, input logic f);
    tbl.push_back('{1'b1, 1'b0, x, avg, 1'b1, lvl, r, f});
    t_dec = avg;
    t_lvl = lvl;
  endtask

  task automatic add_frame(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                           input logic [9:0] d, input logic [9:0] avg, input logic lvl,
                           input logic r, input logic f);
    push_hold(1'b1, a);
    push_hold(1'b1, b);
    push_hold(1'b1, c);
    push_dump(d, avg, lvl, r, f);
  endtask

  initial begin
    // Thresholds fixed at th_hi=0x020, th_lo=0x010 for the whole table.
    add_frame(10'h010, 10'h010, 10'h010, 10'h010, 10'h010, 1'b0, 1'b0, 1'b0);
    add_frame(10'h001, 10'h002, 10'h003, 10'h004, 10'h002, 1'b0, 1'b0, 1'b0);
    add_frame(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FE, 10'h3FE, 1'b0, 1'b0, 1'b0);
    add_frame(10'h1FF, 10'h1FF, 10'h1FF, 10'h1FF, 10'h1FF, 1'b1, 1'b1, 1'b0);
    add_frame(10'h200, 10'h200, 10'h200, 10'h200, 10'h200, 1'b0, 1'b0, 1'b1);
    add_frame(10'h020, 10'h020, 10'h020, 10'h020, 10'h020, 1'b0, 1'b0, 1'b0);
    add_frame(10'h021, 10'h021, 10'h021, 10'h021, 10'h021, 1'b1, 1'b1, 1'b0);
    add_frame(10'h018, 10'h018, 10'h018, 10'h018, 10'h018, 1'b1, 1'b0, 1'b0);
    add_frame(10'h010, 10'h010, 10'h010, 10'h010, 10'h010, 1'b1, 1'b0, 1'b0);
    add_frame(10'h00F, 10'h00F, 10'h00F, 10'h00F, 10'h00F, 1'b0, 1'b0, 1'b1);
    // Enable gap of three cycles between samples 2 and 3; garbage input while idle.
    push_hold(1'b1, 10'h008);
    push_hold(1'b1, 10'h008);
    push_hold(1'b0, 10'h1F0);
    push_hold(1'b0, 10'h1F0);
    push_hold(1'b0, 10'h1F0);
    push_hold(1'b1, 10'h008);
    push_dump(10'h008, 10'h008, 1'b0, 1'b0, 1'b0);
    push_hold(1'b0, 10'h000);

    resetn     = 1'b0;
    clk_enable = 1'b0;
    clear      = 1'b0;
    input_rsvd = 10'h000;
    th_hi      = 10'h020;
    th_lo      = 10'h010;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive_edge(tbl[i].en, tbl[i].clr, tbl[i].x);
      check($sformatf("tbl%0d", i), tbl[i].dec, tbl[i].v, tbl[i].lvl, tbl[i].r, tbl[i].f);
    end

    // Clear with a simultaneous sample, while HIGH and with th_lo low enough to stay HIGH.
    th_lo = 10'h000;
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b1, 1'b0, 10'h030);
      check("pre_clr", m_dec, m_v, m_lvl, m_r, m_f);
    end
    drive_edge(1'b1, 1'b0, 10'h040);
    check("clr_s1", m_dec, m_v, m_lvl, m_r, m_f);
    drive_edge(1'b1, 1'b0, 10'h040);
    check("clr_s2", m_dec, m_v, m_lvl, m_r, m_f);
    drive_edge(1'b1, 1'b1, 10'h040);
    check("clr_edge", 10'h030, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b1, 1'b0, 10'h004);
      check("clr_post", m_dec, m_v, m_lvl, m_r, m_f);
    end
    drive_edge(1'b1, 1'b0, 10'h004);
    check("clr_dump", 10'h004, 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-frame with level_hi=1.
    th_lo = 10'h010;
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b1, 1'b0, 10'h030);
      check("rst_pre", m_dec, m_v, m_lvl, m_r, m_f);
    end
    resetn = 1'b0;
    #2;
    check("rst_async", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b1, 1'b0, 10'h030);
      check("rst_post", m_dec, m_v, m_lvl, m_r, m_f);
    end
    drive_edge(1'b1, 1'b0, 10'h030);
    check("rst_dump", 10'h030, 1'b1, 1'b1, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic       en, clr;
      logic [9:0] x;
      if ($urandom_range(0, 31) == 0) begin
        th_hi = 10'($urandom_range(0, 1023));
        th_lo = 10'($urandom_range(0, 1023));
      end
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 0)
        x = 10'($urandom_range(0, 1023));
      else
        x = 10'(th_hi + 10'($urandom_range(0, 15)) - 10'd8);
      drive_edge(en, clr, x);
      check("rand", m_dec, m_v, m_lvl, m_r, m_f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/filter_decim.md
# filter_decim

Post-filter decimation and level-detect stage, directly downstream of `filter`. Consumes the filter's sfix10_En3 sample stream under the same `clk_enable` qualifier. Averages every DECIM qualified samples into one decimated sample. Runs a two-state hysteresis detector on each decimated sample and emits rise/fall event pulses for the control logic.

## Interface
- `DECIM`, default 8: decimation ratio; power of two, 2..64; L = log2(DECIM).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `clk_enable`  in  1  sample qualifier, same signal that drives `filter`; one sample per cycle while high.
- `clear`  in  1  synchronous frame restart; discards the partial accumulation.
- `input_rsvd`  in  10  signed sfix10_En3; `filter` output_rsvd.
- `th_hi`  in  10  signed sfix10_En3; rise threshold.
- `th_lo`  in  10  signed sfix10_En3; fall threshold.
- `dec_out`  out  10  signed sfix10_En3; decimated average, registered.
- `dec_valid`  out  1  one-cycle strobe; `dec_out` updated this cycle.
- `level_hi`  out  1  hysteresis state (1 = HIGH).
- `event_rise`  out  1  one-cycle pulse on LOW->HIGH.
- `event_fall`  out  1  one-cycle pulse on HIGH->LOW.

## Operation
- Accumulator `acc` is signed, 10+L bits, so it cannot overflow. Phase counter `ph` runs 0..DECIM-1.
- A sample is taken on an edge where `clk_enable`=1 and `clear`=0.
- Sample taken with `ph` < DECIM-1:
  - acc <= acc + input_rsvd (sign-extended).
  - ph <= ph+1.
- Sample taken with `ph` = DECIM-1 (dump):
  - dec_out <= (acc + input_rsvd) >>> L. Arithmetic shift, floor rounding. The result always fits 10 bits, so there is no saturation.
  - dec_valid <= 1.
  - acc <= 0, ph <= 0.
- `clk_enable`=0: acc, ph, dec_out and the FSM hold; all strobes go 0.
- `clear`=1 forces acc <= 0 and ph <= 0. The FSM and dec_out hold. `clear` wins over a simultaneous sample, and that sample is discarded.
- Hysteresis FSM has states LOW and HIGH. It is evaluated only on the dump edge, using the new average A = (acc+input_rsvd)>>>L. `th_hi`/`th_lo` are sampled on that same edge.
  - LOW: if A > th_hi, go to HIGH and pulse event_rise. Otherwise stay LOW.
  - HIGH: if A < th_lo, go to LOW and pulse event_fall. Otherwise stay HIGH.
  - Comparisons are signed and strict. Equality does not transition.
  - th_lo > th_hi is legal; the FSM follows the same rules and may transition on every dump.
- level_hi = (state == HIGH), registered.

## Timing
- Reset values: acc=0, ph=0, dec_out=0x000, dec_valid=0, state=LOW, level_hi=0, event_rise=0, event_fall=0.
- Latency: on the edge that takes the DECIM-th sample, dec_out, dec_valid, level_hi and event_* all update together. They are visible one cycle after that sample is presented.
- dec_valid and event_* are high for exactly one cycle. At most one of event_rise/event_fall is high at a time. Events occur only in a dec_valid cycle.
- Back-to-back frames need no bubble: with continuous `clk_enable`, dec_valid fires every DECIM cycles.
- A gap in `clk_enable` stretches the frame. The average still covers exactly DECIM qualified samples.
- resetn asserted mid-frame clears everything immediately and asynchronously. The first frame after release starts at ph=0.

## Test plan
- DECIM=4, continuous enable, input 0x010 ×4 -> dec_out=0x010, dec_valid for 1 cycle exactly 1 cycle after the 4th sample; repeat with input 0x001,0x002,0x003,0x004 -> dec_out=0x002 (10>>>2, floor).
- Negative and extreme averages:
  - -1,-1,-1,-2 (0x3FF,0x3FF,0x3FF,0x3FE) -> dec_out=0x3FE (-5>>>2 = -2).
  - 0x1FF ×4 -> 0x1FF.
  - 0x200 ×4 -> 0x200.
- Hysteresis: th_hi=0x020, th_lo=0x010.
  - Frame averages 0x020 -> no event, level_hi=0.
  - 0x021 -> event_rise and level_hi=1.
  - 0x018 -> no event.
  - 0x010 -> no event.
  - 0x00F -> event_fall and level_hi=0.
- Enable gaps: 0x008 ×4 delivered with clk_enable=0 for 3 cycles between samples 2 and 3 -> dec_out=0x008. dec_valid fires exactly once, 1 cycle after sample 4.
- `clear` with a simultaneous sample:
  - Two samples of 0x040, then `clear`=1 together with a third 0x040 -> that sample is discarded.
  - Four more samples of 0x004 -> dec_out=0x004.
  - FSM unchanged across the clear.
- resetn pulsed low after 3 of 4 samples while level_hi=1 -> all outputs return to reset values immediately. The next 4 samples of 0x030 (th_hi=0x020) -> dec_out=0x030 and event_rise.
